// File: rtl/dma_xfer_ctrl.sv
// Byte-wise memory-to-memory DMA controller: requests the bus, then moves
// byte_count bytes as READ/WRITE pairs between two incrementing pointers.
module dma_xfer_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [7:0]        byte_count_i,
    input  logic              bus_grant_i,
    input  logic              mem_ready_i,
    output logic              bus_req_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic              data_load_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [7:0]        remaining_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        remaining_q, remaining_d;
    logic              bus_req_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic              busy_q;
    logic              done_q;

    // Next-state logic; addr is loaded only when entering READ or WRITE so it
    // holds its last value everywhere else.
    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (byte_count_i != 8'd0) begin
                        src_ptr_d   = src_addr_i;
                        dst_ptr_d   = dst_addr_i;
                        remaining_d = byte_count_i;
                        state_d     = S_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (bus_grant_i) begin
                    addr_d  = src_ptr_q;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (mem_ready_i) begin
                    addr_d  = dst_ptr_q;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ready_i) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                src_ptr_d   = src_ptr_q + ADDR_W'(1);
                dst_ptr_d   = dst_ptr_q + ADDR_W'(1);
                remaining_d = remaining_q - 8'd1;
                if (remaining_q == 8'd1) begin
                    state_d = S_DONE;
                end else if (bus_grant_i) begin
                    addr_d  = src_ptr_q + ADDR_W'(1);
                    state_d = S_READ;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            addr_q      <= '0;
            remaining_q <= 8'd0;
            bus_req_q   <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            bus_req_q   <= (state_d == S_REQ) || (state_d == S_READ) ||
                           (state_d == S_WRITE) || (state_d == S_NEXT);
            mem_rd_q    <= (state_d == S_READ);
            mem_wr_q    <= (state_d == S_WRITE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign bus_req_o     = bus_req_q;
    assign addr_o        = addr_q;
    assign mem_rd_o      = mem_rd_q;
    assign mem_wr_o      = mem_wr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign remaining_o   = remaining_q;
    assign data_load_n_o = !((state_q == S_READ) && mem_ready_i);

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed bench for dma_xfer_ctrl: a per-cycle vector table for the plain
// transfers plus hand-written sequences for wait states, grant loss and reset abort.
module tb_dma_xfer_ctrl;

    typedef struct {
        logic       start;
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] cnt;
        logic       grant;
        logic       ready;
        logic       busReq;
        logic [7:0] addr;
        logic       rd;
        logic       wr;
        logic       loadN;
        logic       busy;
        logic       done;
        logic [7:0] rem;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] srcAddr;
    logic [7:0] dstAddr;
    logic [7:0] byteCount;
    logic       busGrant;
    logic       memReady;
    logic       busReq;
    logic [7:0] addr;
    logic       memRd;
    logic       memWr;
    logic       dataLoadN;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    dma_xfer_ctrl #(.ADDR_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .src_addr_i    (srcAddr),
        .dst_addr_i    (dstAddr),
        .byte_count_i  (byteCount),
        .bus_grant_i   (busGrant),
        .mem_ready_i   (memReady),
        .bus_req_o     (busReq),
        .addr_o        (addr),
        .mem_rd_o      (memRd),
        .mem_wr_o      (memWr),
        .data_load_n_o (dataLoadN),
        .busy_o        (busy),
        .done_o        (done),
        .remaining_o   (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(input logic st, input logic [7:0] s, input logic [7:0] d,
                                   input logic [7:0] c, input logic g, input logic r,
                                   input logic br, input logic [7:0] a, input logic rd,
                                   input logic wr, input logic ln, input logic bz,
                                   input logic dn, input logic [7:0] rm);
        vec_t v;
        v.start = st; v.src = s; v.dst = d; v.cnt = c; v.grant = g; v.ready = r;
        v.busReq = br; v.addr = a; v.rd = rd; v.wr = wr; v.loadN = ln;
        v.busy = bz; v.done = dn; v.rem = rm;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic st, input logic [7:0] s, input logic [7:0] d,
                                 input logic [7:0] c, input logic g, input logic r);
        start     = st;
        srcAddr   = s;
        dstAddr   = d;
        byteCount = c;
        busGrant  = g;
        memReady  = r;
    endtask

    task automatic checkOutput(input string name, input logic br, input logic [7:0] a,
                               input logic rd, input logic wr, input logic ln,
                               input logic bz, input logic dn, input logic [7:0] rm);
        logic [21:0] got;
        logic [21:0] exp;
        #1;
        got = {busReq, addr, memRd, memWr, dataLoadN, busy, done, remaining};
        exp = {br, a, rd, wr, ln, bz, dn, rm};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got busReq=%b addr=%h rd=%b wr=%b loadN=%b busy=%b done=%b rem=%h, expected busReq=%b addr=%h rd=%b wr=%b loadN=%b busy=%b done=%b rem=%h",
                     name, busReq, addr, memRd, memWr, dataLoadN, busy, done, remaining,
                     br, a, rd, wr, ln, bz, dn, rm);
        end
    endtask

    task automatic runCycle(input string name, input logic st, input logic [7:0] s,
                            input logic [7:0] d, input logic [7:0] c, input logic g,
                            input logic r, input logic br, input logic [7:0] a,
                            input logic rd, input logic wr, input logic ln,
                            input logic bz, input logic dn, input logic [7:0] rm);
        applyStimulus(st, s, d, c, g, r);
        checkOutput(name, br, a, rd, wr, ln, bz, dn, rm);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Basic transfer 0x10 -> 0x80, three bytes, no wait states
        addVec(1, 8'h10, 8'h80, 8'd3, 1, 1,  0, 8'h00, 0, 0, 1, 0, 0, 8'd0);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h00, 0, 0, 1, 1, 0, 8'd3);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h10, 1, 0, 0, 1, 0, 8'd3);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h80, 0, 1, 1, 1, 0, 8'd3);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h80, 0, 0, 1, 1, 0, 8'd3);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h11, 1, 0, 0, 1, 0, 8'd2);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h81, 0, 1, 1, 1, 0, 8'd2);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h81, 0, 0, 1, 1, 0, 8'd2);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h12, 1, 0, 0, 1, 0, 8'd1);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h82, 0, 1, 1, 1, 0, 8'd1);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h82, 0, 0, 1, 1, 0, 8'd1);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  0, 8'h82, 0, 0, 1, 1, 1, 8'd0);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  0, 8'h82, 0, 0, 1, 0, 0, 8'd0);
        // Zero count goes straight to DONE without touching the bus
        addVec(1, 8'h55, 8'h66, 8'd0, 1, 1,  0, 8'h82, 0, 0, 1, 0, 0, 8'd0);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  0, 8'h82, 0, 0, 1, 1, 1, 8'd0);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  0, 8'h82, 0, 0, 1, 0, 0, 8'd0);
        // Pointer wrap, with stray starts mid-transfer that must be ignored
        addVec(1, 8'hFF, 8'hFE, 8'd3, 1, 1,  0, 8'h82, 0, 0, 1, 0, 0, 8'd0);
        addVec(1, 8'h33, 8'h44, 8'd0, 1, 1,  1, 8'h82, 0, 0, 1, 1, 0, 8'd3);
        addVec(1, 8'h33, 8'h44, 8'd5, 1, 1,  1, 8'hFF, 1, 0, 0, 1, 0, 8'd3);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'hFE, 0, 1, 1, 1, 0, 8'd3);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'hFE, 0, 0, 1, 1, 0, 8'd3);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h00, 1, 0, 0, 1, 0, 8'd2);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'hFF, 0, 1, 1, 1, 0, 8'd2);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'hFF, 0, 0, 1, 1, 0, 8'd2);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h01, 1, 0, 0, 1, 0, 8'd1);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h00, 0, 1, 1, 1, 0, 8'd1);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h00, 0, 0, 1, 1, 0, 8'd1);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  0, 8'h00, 0, 0, 1, 1, 1, 8'd0);
        addVec(0, 8'h00, 8'h00, 8'd0, 1, 1,  0, 8'h00, 0, 0, 1, 0, 0, 8'd0);

        rst = 1'b1;
        applyStimulus(0, 8'h00, 8'h00, 8'd0, 0, 0);
        #1 rst = 1'b0;
        checkOutput("reset", 0, 8'h00, 0, 0, 1, 0, 0, 8'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].start, vecs[i].src, vecs[i].dst, vecs[i].cnt,
                          vecs[i].grant, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].busReq, vecs[i].addr, vecs[i].rd,
                        vecs[i].wr, vecs[i].loadN, vecs[i].busy, vecs[i].done, vecs[i].rem);
            @(posedge clk);
            @(negedge clk);
        end

        // Two wait cycles in both READ and WRITE, single byte
        runCycle("wait0", 1, 8'h20, 8'h30, 8'd1, 1, 0,  0, 8'h00, 0, 0, 1, 0, 0, 8'd0);
        runCycle("wait1", 0, 8'h00, 8'h00, 8'd0, 1, 0,  1, 8'h00, 0, 0, 1, 1, 0, 8'd1);
        runCycle("wait2", 0, 8'h00, 8'h00, 8'd0, 1, 0,  1, 8'h20, 1, 0, 1, 1, 0, 8'd1);
        runCycle("wait3", 0, 8'h00, 8'h00, 8'd0, 1, 0,  1, 8'h20, 1, 0, 1, 1, 0, 8'd1);
        runCycle("wait4", 0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h20, 1, 0, 0, 1, 0, 8'd1);
        runCycle("wait5", 0, 8'h00, 8'h00, 8'd0, 1, 0,  1, 8'h30, 0, 1, 1, 1, 0, 8'd1);
        runCycle("wait6", 0, 8'h00, 8'h00, 8'd0, 1, 0,  1, 8'h30, 0, 1, 1, 1, 0, 8'd1);
        runCycle("wait7", 0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h30, 0, 1, 1, 1, 0, 8'd1);
        runCycle("wait8", 0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h30, 0, 0, 1, 1, 0, 8'd1);
        runCycle("wait9", 0, 8'h00, 8'h00, 8'd0, 1, 1,  0, 8'h30, 0, 0, 1, 1, 1, 8'd0);
        runCycle("wait10", 0, 8'h00, 8'h00, 8'd0, 1, 1, 0, 8'h30, 0, 0, 1, 0, 0, 8'd0);

        // Grant drops during the first WRITE; NEXT falls back to REQ
        runCycle("grant0", 1, 8'h40, 8'h50, 8'd2, 1, 1,  0, 8'h30, 0, 0, 1, 0, 0, 8'd0);
        runCycle("grant1", 0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h30, 0, 0, 1, 1, 0, 8'd2);
        runCycle("grant2", 0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h40, 1, 0, 0, 1, 0, 8'd2);
        runCycle("grant3", 0, 8'h00, 8'h00, 8'd0, 0, 1,  1, 8'h50, 0, 1, 1, 1, 0, 8'd2);
        runCycle("grant4", 0, 8'h00, 8'h00, 8'd0, 0, 1,  1, 8'h50, 0, 0, 1, 1, 0, 8'd2);
        runCycle("grant5", 0, 8'h00, 8'h00, 8'd0, 0, 1,  1, 8'h50, 0, 0, 1, 1, 0, 8'd1);
        runCycle("grant6", 0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h50, 0, 0, 1, 1, 0, 8'd1);
        runCycle("grant7", 0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h41, 1, 0, 0, 1, 0, 8'd1);
        runCycle("grant8", 0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h51, 0, 1, 1, 1, 0, 8'd1);
        runCycle("grant9", 0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h51, 0, 0, 1, 1, 0, 8'd1);
        runCycle("grant10", 0, 8'h00, 8'h00, 8'd0, 1, 1, 0, 8'h51, 0, 0, 1, 1, 1, 8'd0);
        runCycle("grant11", 0, 8'h00, 8'h00, 8'd0, 1, 1, 0, 8'h51, 0, 0, 1, 0, 0, 8'd0);

        // Reset asserted mid-cycle in the second READ of a four-byte transfer
        runCycle("abort0", 1, 8'h60, 8'h70, 8'd4, 1, 1,  0, 8'h51, 0, 0, 1, 0, 0, 8'd0);
        runCycle("abort1", 0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h51, 0, 0, 1, 1, 0, 8'd4);
        runCycle("abort2", 0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h60, 1, 0, 0, 1, 0, 8'd4);
        runCycle("abort3", 0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h70, 0, 1, 1, 1, 0, 8'd4);
        runCycle("abort4", 0, 8'h00, 8'h00, 8'd0, 1, 1,  1, 8'h70, 0, 0, 1, 1, 0, 8'd4);
        applyStimulus(0, 8'h00, 8'h00, 8'd0, 1, 1);
        checkOutput("abort5", 1, 8'h61, 1, 0, 0, 1, 0, 8'd3);
        #1 rst = 1'b0;
        checkOutput("abortAsync", 0, 8'h00, 0, 0, 1, 0, 0, 8'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abortHeld", 0, 8'h00, 0, 0, 1, 0, 0, 8'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        runCycle("idle0", 0, 8'h00, 8'h00, 8'd0, 1, 1,  0, 8'h00, 0, 0, 1, 0, 0, 8'd0);
        runCycle("idle1", 0, 8'h00, 8'h00, 8'd0, 1, 1,  0, 8'h00, 0, 0, 1, 0, 0, 8'd0);
        runCycle("restart0", 1, 8'h90, 8'hA0, 8'd1, 1, 1, 0, 8'h00, 0, 0, 1, 0, 0, 8'd0);
        runCycle("restart1", 0, 8'h00, 8'h00, 8'd0, 1, 1, 1, 8'h00, 0, 0, 1, 1, 0, 8'd1);
        runCycle("restart2", 0, 8'h00, 8'h00, 8'd0, 1, 1, 1, 8'h90, 1, 0, 0, 1, 0, 8'd1);
        runCycle("restart3", 0, 8'h00, 8'h00, 8'd0, 1, 1, 1, 8'hA0, 0, 1, 1, 1, 0, 8'd1);
        runCycle("restart4", 0, 8'h00, 8'h00, 8'd0, 1, 1, 1, 8'hA0, 0, 0, 1, 1, 0, 8'd1);
        runCycle("restart5", 0, 8'h00, 8'h00, 8'd0, 1, 1, 0, 8'hA0, 0, 0, 1, 1, 1, 8'd0);
        runCycle("restart6", 0, 8'h00, 8'h00, 8'd0, 1, 1, 0, 8'hA0, 0, 0, 1, 0, 0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_xfer_ctrl.md
DMA_XFER_CTRL -- requirements
Module: dma_xfer_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, sets the memory address width in bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  one-cycle transfer request; sampled in IDLE only.
REQ-005 src_addr  input  ADDR_W  first source address; captured on accepted start.
REQ-006 dst_addr  input  ADDR_W  first destination address; captured on accepted start.
REQ-007 byte_count  input  8  number of bytes to move (0..255); captured on accepted start.
REQ-008 bus_grant  input  1  arbiter grant of the memory bus.
REQ-009 mem_ready  input  1  memory completes the current read/write this cycle.
REQ-010 bus_req  output  1  bus request to the arbiter.
REQ-011 addr  output  ADDR_W  memory address for the current access.
REQ-012 mem_rd  output  1  memory read strobe.
REQ-013 mem_wr  output  1  memory write strobe.
REQ-014 data_load_n  output  1  active-low load enable to the downstream 8-bit data holding register.
REQ-015 busy  output  1  high from accepted start until return to IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 remaining  output  8  bytes not yet written.

Function
REQ-018 States: IDLE, REQ, READ, WRITE, NEXT, DONE; all transitions occur on the rising clk edge.
REQ-019 In IDLE with start=1 and byte_count!=0: capture src_ptr, dst_ptr and remaining from the inputs, then enter REQ.
REQ-020 In IDLE with start=1 and byte_count=0: enter DONE directly; no bus_req, mem_rd or mem_wr is asserted.
REQ-021 In REQ: bus_req=1; hold in REQ until bus_grant=1, then enter READ.
REQ-022 bus_req stays 1 in REQ, READ, WRITE and NEXT, and is 0 in IDLE and DONE.
REQ-023 In READ: addr=src_ptr and mem_rd=1; hold while mem_ready=0; enter WRITE on mem_ready=1.
REQ-024 data_load_n is combinational: 0 only when state=READ and mem_ready=1, otherwise 1, giving exactly one low cycle per byte.
REQ-025 In WRITE: addr=dst_ptr and mem_wr=1; hold while mem_ready=0; enter NEXT on mem_ready=1.
REQ-026 In NEXT: src_ptr+1, dst_ptr+1 and remaining-1 are all applied on the same edge.
REQ-027 Exit from NEXT: if the decremented remaining is 0, enter DONE; else if bus_grant=1, enter READ; else enter REQ.
REQ-028 Pointers wrap modulo 2^ADDR_W (all-ones + 1 = 0) with no error indication.
REQ-029 In DONE: done=1 for exactly one cycle, then return to IDLE.
REQ-030 busy=1 in every state except IDLE.
REQ-031 start is ignored outside IDLE; the transfer in progress is unaffected.
REQ-032 bus_grant is sampled only in REQ and NEXT; a grant drop during READ or WRITE does not abort the access in progress.
REQ-033 In IDLE, REQ, NEXT and DONE: mem_rd=0, mem_wr=0, and addr holds its last registered value.
REQ-034 mem_rd and mem_wr are never 1 in the same cycle.
REQ-035 Minimum cost is 3 cycles per byte (READ, WRITE, NEXT) with mem_ready and bus_grant held at 1.

Reset
REQ-036 rst=0 immediately forces: state IDLE; bus_req=0, mem_rd=0, mem_wr=0, data_load_n=1, busy=0, done=0; addr=0, remaining=0; pointers=0.
REQ-037 Reset during any state aborts the transfer with no done pulse; after rst rises, the block waits in IDLE for a new start.

Verification
REQ-038 Basic transfer: src=0x10, dst=0x80, count=3, grant=1, ready=1 -> addr sequence 10,80,11,81,12,82; three single-cycle data_load_n lows; done 10 cycles after the start edge; remaining=0.
REQ-039 Zero count: start with count=0 -> done pulses on the next cycle; bus_req, mem_rd and mem_wr stay 0 throughout.
REQ-040 Wait states: ready low for 2 cycles in each READ and WRITE, count=1 -> mem_rd held 3 cycles, data_load_n low only in the third, mem_wr held 3 cycles, single done pulse.
REQ-041 Grant loss: count=2, grant deasserted during the first WRITE -> the first write completes, NEXT enters REQ, the transfer resumes at src+1 when grant returns.
REQ-042 Wrap: src=0xFF, dst=0xFE, count=3 -> read addrs FF,00,01; write addrs FE,FF,00.
REQ-043 Abort and restart: rst low during the second READ of a count=4 transfer -> all outputs return to reset values at once, no done; a subsequent start runs cleanly from the new inputs.
